// File: rtl/ram_arb_2p.sv
// Two-port arbiter sharing a 64x16 single-port RAM (registered read address, write-first).
// Default build is round-robin; define RAM_ARB_FIXED_PRIO_EN for port-0 priority with a port-1 starvation guard.
module ram_arb_2p #(
  parameter int AW       = 6,
  parameter int DW       = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] a0,
  input  logic [AW-1:0] a1,
  input  logic [DW-1:0] di0,
  input  logic [DW-1:0] di1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_di,
  input  logic [DW-1:0] ram_do
);

  if (AW != 6 || MAX_WAIT < 1) begin : g_cfg_err
    $error("ram_arb_2p: AW must be 6 and MAX_WAIT at least 1");
  end

  logic prio_q, prio_d;
  logic rvalid0_q, rvalid1_q;
  logic pick1;

`ifdef RAM_ARB_FIXED_PRIO_EN
  localparam int WW = $clog2(MAX_WAIT + 1);
  logic [WW-1:0] wait_q, wait_d;

  // prio_q stays 0 here, so contention is decided by the starvation counter alone.
  assign pick1  = prio_q | (wait_q == WW'(MAX_WAIT));
  assign prio_d = 1'b0;

  always_comb begin
    wait_d = wait_q;
    if (gnt1)      wait_d = '0;
    else if (req1) wait_d = wait_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_q <= '0;
    else        wait_q <= wait_d;
  end
`else
  assign pick1 = prio_q;

  always_comb begin
    prio_d = prio_q;
    if (gnt0)      prio_d = 1'b1;
    else if (gnt1) prio_d = 1'b0;
  end
`endif

  always_comb begin
    gnt0 = req0;
    gnt1 = req1;
    if (req0 && req1) begin
      gnt0 = !pick1;
      gnt1 = pick1;
    end
  end

  assign ram_en = gnt0 | gnt1;
  assign ram_we = gnt1 ? we1 : (gnt0 & we0);
  assign ram_a  = gnt1 ? a1  : a0;
  assign ram_di = gnt1 ? di1 : di0;

  // Read data comes straight from the RAM; rvalid tags which port owns it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      prio_q    <= prio_d;
      rvalid0_q <= gnt0 & ~we0;
      rvalid1_q <= gnt1 & ~we1;
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata   = ram_do;

endmodule

// File: tb/tb_ram_arb_2p.sv
// Directed bench for ram_arb_2p with a behavioural 64x16 write-first RAM attached.
module tb_ram_arb_2p;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we0, we1;
  logic [5:0]  a0, a1;
  logic [15:0] di0, di1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [15:0] rdata;
  logic        ram_en, ram_we;
  logic [5:0]  ram_a;
  logic [15:0] ram_di, ram_do;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_arb_2p #(.AW(6), .DW(16), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .a0(a0), .a1(a1), .di0(di0), .di1(di1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .ram_en(ram_en), .ram_we(ram_we),
    .ram_a(ram_a), .ram_di(ram_di), .ram_do(ram_do)
  );

  // Single-port RAM: registered read address, write-first.
  logic [15:0] mem [64];
  logic [5:0]  ra_q;
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'hC000 + 16'(i);
    ra_q = '0;
  end
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_a] <= ram_di;
      ra_q <= ram_a;
    end
  end
  assign ram_do = mem[ra_q];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    a0 = '0; a1 = '0; di0 = '0; di1 = '0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    tick();
    #1;
    total++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin bad++; $display("FAIL rst_gnt got=%b%b exp=00", gnt0, gnt1); end
    total++; if (ram_en !== 1'b0 || ram_we !== 1'b0) begin bad++; $display("FAIL rst_ram got en=%b we=%b exp=0 0", ram_en, ram_we); end
    total++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%b%b exp=00", rvalid0, rvalid1); end
    total++; if (rdata !== ram_do) begin bad++; $display("FAIL rst_rdata got=%h exp=%h", rdata, ram_do); end
    tick();
    rst_n = 1;
  endtask

  task automatic test_write_read();
    req0 = 1; we0 = 1; a0 = 6'd5; di0 = 16'hA5A5;
    #1;
    total++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin bad++; $display("FAIL wr_gnt got=%b%b exp=10", gnt0, gnt1); end
    total++; if (ram_en !== 1'b1 || ram_we !== 1'b1) begin bad++; $display("FAIL wr_ram got en=%b we=%b exp=1 1", ram_en, ram_we); end
    total++; if (ram_a !== 6'd5 || ram_di !== 16'hA5A5) begin bad++; $display("FAIL wr_addr got a=%0d di=%h exp a=5 di=a5a5", ram_a, ram_di); end
    tick();
    req0 = 0; we0 = 0;
    req1 = 1; we1 = 0; a1 = 6'd5;
    #1;
    total++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin bad++; $display("FAIL rd_gnt got=%b%b exp=01", gnt0, gnt1); end
    total++; if (ram_we !== 1'b0 || ram_a !== 6'd5) begin bad++; $display("FAIL rd_ram got we=%b a=%0d exp we=0 a=5", ram_we, ram_a); end
    total++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin bad++; $display("FAIL wr_norvalid got=%b%b exp=00", rvalid0, rvalid1); end
    tick();
    req1 = 0;
    #1;
    total++; if (rvalid1 !== 1'b1 || rvalid0 !== 1'b0) begin bad++; $display("FAIL rd_rvalid got=%b%b exp=01", rvalid0, rvalid1); end
    total++; if (rdata !== 16'hA5A5) begin bad++; $display("FAIL rd_data got=%h exp=a5a5", rdata); end
    tick();
    total++; if (rvalid1 !== 1'b0) begin bad++; $display("FAIL rd_pulse got=%b exp=0", rvalid1); end
  endtask

  task automatic test_alternate();
    logic p0, p1;
    test_reset();
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; a0 = 6'd10; a1 = 6'd20;
    p0 = 0; p1 = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      total++; if (gnt0 !== (k % 2 == 0) || gnt1 !== (k % 2 == 1)) begin bad++; $display("FAIL alt_gnt%0d got=%b%b exp=%b%b", k, gnt0, gnt1, k % 2 == 0, k % 2 == 1); end
      total++; if (rvalid0 !== p0 || rvalid1 !== p1) begin bad++; $display("FAIL alt_rvalid%0d got=%b%b exp=%b%b", k, rvalid0, rvalid1, p0, p1); end
      if (p0 || p1) begin
        total++; if (rdata !== (p0 ? 16'hC00A : 16'hC014)) begin bad++; $display("FAIL alt_data%0d got=%h exp=%h", k, rdata, p0 ? 16'hC00A : 16'hC014); end
      end
      p0 = (k % 2 == 0);
      p1 = (k % 2 == 1);
      tick();
    end
    idle();
    #1;
    total++; if (rvalid1 !== 1'b1 || rvalid0 !== 1'b0 || rdata !== 16'hC014) begin bad++; $display("FAIL alt_last got=%b%b %h exp=01 c014", rvalid0, rvalid1, rdata); end
    tick();
  endtask

  task automatic test_fixed_prio();
    test_reset();
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; a0 = 6'd10; a1 = 6'd20;
    for (int k = 0; k < 10; k++) begin
      #1;
      total++; if (gnt1 !== (k == 4 || k == 9) || gnt0 !== !(k == 4 || k == 9)) begin bad++; $display("FAIL fix_gnt%0d got=%b%b exp=%b%b", k, gnt0, gnt1, !(k == 4 || k == 9), k == 4 || k == 9); end
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_back_to_back();
    req0 = 1; we0 = 1; a0 = 6'd63; di0 = 16'h1234;
    #1;
    total++; if (gnt0 !== 1'b1 || ram_a !== 6'd63) begin bad++; $display("FAIL b2b_wr got gnt0=%b a=%0d exp 1 63", gnt0, ram_a); end
    tick();
    req0 = 0; we0 = 0;
    req1 = 1; we1 = 0; a1 = 6'd63;
    #1;
    total++; if (gnt1 !== 1'b1) begin bad++; $display("FAIL b2b_rdgnt got=%b exp=1", gnt1); end
    tick();
    req1 = 0;
    #1;
    total++; if (rvalid1 !== 1'b1 || rdata !== 16'h1234) begin bad++; $display("FAIL b2b_data got rv=%b %h exp 1 1234", rvalid1, rdata); end
    tick();
  endtask

  task automatic test_reset_inflight();
    req0 = 1; we0 = 0; a0 = 6'd10;
    #1;
    total++; if (gnt0 !== 1'b1) begin bad++; $display("FAIL inf_gnt got=%b exp=1", gnt0); end
    #1;
    rst_n = 0;
    #1;
    total++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin bad++; $display("FAIL inf_rv_a got=%b%b exp=00", rvalid0, rvalid1); end
    req0 = 0;
    tick();
    total++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin bad++; $display("FAIL inf_rv_b got=%b%b exp=00", rvalid0, rvalid1); end
    rst_n = 1;
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; a0 = 6'd10; a1 = 6'd20;
    #1;
    total++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin bad++; $display("FAIL inf_first got=%b%b exp=10", gnt0, gnt1); end
    total++; if (rvalid0 !== 1'b0) begin bad++; $display("FAIL inf_rv_c got=%b exp=0", rvalid0); end
    tick();
    idle();
    #1;
    total++; if (rvalid0 !== 1'b1 || rdata !== 16'hC00A) begin bad++; $display("FAIL inf_after got rv=%b %h exp 1 c00a", rvalid0, rdata); end
    tick();
  endtask

  initial begin
    idle();
    rst_n = 1;
    #2;
    test_reset();
    test_write_read();
`ifdef RAM_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`else
    test_alternate();
`endif
    test_back_to_back();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
